// File: rtl/eq2_pkg.sv
// -----------------------------------------------------------------------------
// eq2_pkg
// Definitions shared by the operator entry path of the quadratic-equation
// datapath: entry state encoding, the largest value an operator can type,
// and the idle level of the active-low push buttons.
// -----------------------------------------------------------------------------
package eq2_pkg;

   // VAZIO: nothing typed, EDITANDO: digits being typed, PRONTO: entry confirmed
   typedef enum logic [1:0] {
      VAZIO    = 2'd0,
      EDITANDO = 2'd1,
      PRONTO   = 2'd2
   } estado_t;

   localparam logic [15:0] MAX_VALOR    = 16'd9999;
   localparam logic        KEY_RELEASED = 1'b1;

endpackage

// File: rtl/debounce_tecla.sv
// -----------------------------------------------------------------------------
// debounce_tecla
// Conditions one raw active-low push button: 2-flop synchronizer, stability
// counter and accepted level. Emits a single-cycle press pulse when the
// accepted level goes from released to pressed; releases are silent.
//
// Ports:
//   clk    system clock
//   rst    asynchronous reset, active-high
//   key_n  raw push button, active-low
//   press  one-cycle pulse per accepted press
// -----------------------------------------------------------------------------
module debounce_tecla
   import eq2_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic press
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_a;
   logic             sync_b;
   logic             nivel;
   logic [CNT_W-1:0] cnt;

   // The counter only runs while the synchronized level disagrees with the
   // accepted one; any glitch back to the accepted level restarts it, so a
   // bouncing contact never gets accepted until it has been steady for
   // DEBOUNCE_CYCLES consecutive samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a <= KEY_RELEASED;
         sync_b <= KEY_RELEASED;
         nivel  <= KEY_RELEASED;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         sync_a <= key_n;
         sync_b <= sync_a;
         press  <= 1'b0;
         if (sync_b == nivel) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            nivel <= sync_b;
            cnt   <= '0;
            press <= (sync_b != KEY_RELEASED);
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/leitor_decimal.sv
// -----------------------------------------------------------------------------
// leitor_decimal
// Operator entry block: accumulates up to MAX_DIGITOS decimal digits read
// from four switches into a binary value, under control of three active-low
// push buttons (append digit, confirm, clear).
//
// Ports:
//   clk             system clock
//   rst             asynchronous reset, active-high
//   digito[3:0]     switch value of the digit to append
//   key_digito_n    push button: append digito
//   key_confirma_n  push button: confirm entry
//   key_apaga_n     push button: clear entry
//   valor[15:0]     last confirmed value
//   valido          one-cycle strobe when valor is updated
//   parcial[15:0]   value being typed (for the 7-segment display)
//   ndigitos[2:0]   number of digits in parcial
//   erro            one-cycle strobe when a press is rejected
// -----------------------------------------------------------------------------
module leitor_decimal
   import eq2_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int MAX_DIGITOS     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  digito,
   input  logic        key_digito_n,
   input  logic        key_confirma_n,
   input  logic        key_apaga_n,
   output logic [15:0] valor,
   output logic        valido,
   output logic [15:0] parcial,
   output logic [2:0]  ndigitos,
   output logic        erro
);

   estado_t     estado;
   estado_t     estado_next;
   logic [3:0]  dig_a;
   logic [3:0]  dig_s;
   logic        press_digito;
   logic        press_confirma;
   logic        press_apaga;
   logic        ev_apaga;
   logic        ev_confirma;
   logic        ev_digito;
   logic        dig_legal;
   logic        cheio;
   logic [15:0] parcial_x10;
   logic [15:0] valor_next;
   logic [15:0] parcial_next;
   logic [2:0]  ndigitos_next;
   logic        valido_next;
   logic        erro_next;

   debounce_tecla #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_digito (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_digito_n),
      .press (press_digito)
   );

   debounce_tecla #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_confirma (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_confirma_n),
      .press (press_confirma)
   );

   debounce_tecla #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_apaga (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_apaga_n),
      .press (press_apaga)
   );

   // The switches settle long before a debounced press arrives, so a plain
   // two-flop synchronizer on the bus is enough.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dig_a <= 4'd0;
         dig_s <= 4'd0;
      end else begin
         dig_a <= digito;
         dig_s <= dig_a;
      end
   end

   // Only one event is handled per cycle: apaga beats confirma beats digito.
   assign ev_apaga    = press_apaga;
   assign ev_confirma = press_confirma & ~press_apaga;
   assign ev_digito   = press_digito & ~press_confirma & ~press_apaga;

   assign dig_legal   = (dig_s <= 4'd9);
   assign cheio       = (ndigitos == 3'(MAX_DIGITOS));
   assign parcial_x10 = (parcial << 3) + (parcial << 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado   <= VAZIO;
         valor    <= 16'd0;
         parcial  <= 16'd0;
         ndigitos <= 3'd0;
         valido   <= 1'b0;
         erro     <= 1'b0;
      end else begin
         estado   <= estado_next;
         valor    <= valor_next;
         parcial  <= parcial_next;
         ndigitos <= ndigitos_next;
         valido   <= valido_next;
         erro     <= erro_next;
      end
   end

   // A legal digit outside EDITANDO always starts a fresh entry, whether
   // nothing was typed yet or the previous entry was already confirmed.
   always_comb begin
      estado_next = estado;
      if (ev_apaga) begin
         estado_next = VAZIO;
      end else if (ev_confirma) begin
         if (estado == EDITANDO) estado_next = PRONTO;
      end else if (ev_digito && dig_legal) begin
         if (estado != EDITANDO) estado_next = EDITANDO;
      end
   end

   // valor only moves on a confirm from EDITANDO; parcial and ndigitos stay
   // on display after the confirm until a clear or a new digit.
   always_comb begin
      valor_next    = valor;
      parcial_next  = parcial;
      ndigitos_next = ndigitos;
      valido_next   = 1'b0;
      erro_next     = 1'b0;
      if (ev_apaga) begin
         parcial_next  = 16'd0;
         ndigitos_next = 3'd0;
      end else if (ev_confirma) begin
         case (estado)
            VAZIO:    erro_next = 1'b1;
            EDITANDO: begin
               valor_next  = parcial;
               valido_next = 1'b1;
            end
            default:  ;
         endcase
      end else if (ev_digito) begin
         if (!dig_legal) begin
            erro_next = 1'b1;
         end else if (estado != EDITANDO) begin
            parcial_next  = {12'd0, dig_s};
            ndigitos_next = 3'd1;
         end else if (cheio) begin
            erro_next = 1'b1;
         end else begin
            parcial_next  = parcial_x10 + {12'd0, dig_s};
            ndigitos_next = ndigitos + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_leitor_decimal.sv
// -----------------------------------------------------------------------------
// tb_leitor_decimal
// Self-checking bench for leitor_decimal with a short debounce window.
// Every press drives a digit-list model of the entry; any visible reaction
// it predicts is queued and a monitor matches it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_leitor_decimal;
   import eq2_pkg::*;

   localparam int DEB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  digito = 4'd0;
   logic        keyDigN = 1'b1;
   logic        keyConfN = 1'b1;
   logic        keyApagaN = 1'b1;
   logic [15:0] valor;
   logic        valido;
   logic [15:0] parcial;
   logic [2:0]  ndigitos;
   logic        erro;

   leitor_decimal #(.DEBOUNCE_CYCLES(DEB), .MAX_DIGITOS(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .digito         (digito),
      .key_digito_n   (keyDigN),
      .key_confirma_n (keyConfN),
      .key_apaga_n    (keyApagaN),
      .valor          (valor),
      .valido         (valido),
      .parcial        (parcial),
      .ndigitos       (ndigitos),
      .erro           (erro)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valido;
      logic        erro;
      logic [15:0] valor;
      logic [15:0] parcial;
      logic [2:0]  ndig;
   } expT;

   expT expQ[$];
   int  testsRun = 0;
   int  testsFailed = 0;

   int  modelDigs[$];
   bit  modelPronto = 1'b0;
   int  modelValor = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic int modelParcial();
      int v = 0;
      foreach (modelDigs[i]) v = v * 10 + modelDigs[i];
      return v;
   endfunction

   task automatic modelReset();
      modelDigs.delete();
      modelPronto = 1'b0;
      modelValor = 0;
   endtask

   // The entry is kept as a list of typed digits; the reaction to one
   // accepted event is queued only when it is visible on the outputs.
   task automatic modelStep(input bit apaga, input bit conf, input bit dig, input int d);
      expT e;
      int  oldP;
      int  oldN;
      oldP = modelParcial();
      oldN = modelDigs.size();
      e.valido = 1'b0;
      e.erro = 1'b0;
      if (apaga) begin
         modelDigs.delete();
         modelPronto = 1'b0;
      end else if (conf) begin
         if (modelDigs.size() == 0) e.erro = 1'b1;
         else if (!modelPronto) begin
            modelValor = oldP;
            e.valido = 1'b1;
            modelPronto = 1'b1;
         end
      end else if (dig) begin
         if (d > 9) e.erro = 1'b1;
         else if (modelPronto || modelDigs.size() == 0) begin
            modelDigs.delete();
            modelDigs.push_back(d);
            modelPronto = 1'b0;
         end else if (modelDigs.size() == 4) e.erro = 1'b1;
         else modelDigs.push_back(d);
      end
      e.valor = 16'(modelValor);
      e.parcial = 16'(modelParcial());
      e.ndig = 3'(modelDigs.size());
      if (e.valido || e.erro || modelParcial() != oldP || modelDigs.size() != oldN)
         expQ.push_back(e);
   endtask

   task automatic applyStimulus(input bit apaga, input bit conf, input bit dig, input int d);
      @(negedge clk);
      digito = 4'(d);
      repeat (3) @(negedge clk);
      modelStep(apaga, conf, dig, d);
      keyApagaN = !apaga;
      keyConfN = !conf;
      keyDigN = !dig;
      repeat (12) @(negedge clk);
      keyApagaN = 1'b1;
      keyConfN = 1'b1;
      keyDigN = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   // Contact bounce shorter than the debounce window, then a steady press.
   task automatic bounceStimulus(input int d);
      @(negedge clk);
      digito = 4'(d);
      repeat (3) @(negedge clk);
      modelStep(1'b0, 1'b0, 1'b1, d);
      for (int i = 0; i < 10; i++) begin
         keyDigN = (i % 2 == 0) ? 1'b0 : 1'b1;
         repeat (2) @(negedge clk);
      end
      keyDigN = 1'b0;
      repeat (12) @(negedge clk);
      keyDigN = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   task automatic waitDrain(input string name);
      for (int i = 0; i < 100 && expQ.size() > 0; i++) @(negedge clk);
      checkOutput(name, expQ.size(), 0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_valor"}, int'(valor), 0);
      checkOutput({tag, "_parcial"}, int'(parcial), 0);
      checkOutput({tag, "_ndigitos"}, int'(ndigitos), 0);
      checkOutput({tag, "_valido"}, int'(valido), 0);
      checkOutput({tag, "_erro"}, int'(erro), 0);
   endtask

   // Any visible reaction consumes one queued expectation; a reaction with
   // nothing queued is a spurious event.
   logic [15:0] prevParcial = 16'd0;
   logic [2:0]  prevNdig = 3'd0;
   always @(negedge clk) begin
      expT e;
      if (!rst && (valido || erro || parcial != prevParcial || ndigitos != prevNdig)) begin
         if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL spurious_output: got valido=%0b erro=%0b parcial=%0d ndigitos=%0d, expected no change",
                     valido, erro, parcial, ndigitos);
         end else begin
            e = expQ.pop_front();
            checkOutput("valido", int'(valido), int'(e.valido));
            checkOutput("erro", int'(erro), int'(e.erro));
            checkOutput("valor", int'(valor), int'(e.valor));
            checkOutput("parcial", int'(parcial), int'(e.parcial));
            checkOutput("ndigitos", int'(ndigitos), int'(e.ndig));
         end
      end
      prevParcial = parcial;
      prevNdig = ndigitos;
   end

   initial begin
      int op;
      int d;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkAllZero("reset");

      // 1,2,3,4 then confirm
      for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, i);
      applyStimulus(1'b0, 1'b1, 1'b0, 0);
      waitDrain("drain_1234");

      // full entry then one more digit
      applyStimulus(1'b1, 1'b0, 1'b0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 9);
      applyStimulus(1'b0, 1'b0, 1'b1, 5);
      waitDrain("drain_overflow");

      // bouncing key from an empty entry
      applyStimulus(1'b1, 1'b0, 1'b0, 0);
      bounceStimulus(6);
      waitDrain("drain_bounce");

      // illegal digit, then confirm with nothing typed
      applyStimulus(1'b0, 1'b0, 1'b1, 12);
      applyStimulus(1'b1, 1'b0, 1'b0, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 0);
      waitDrain("drain_errors");

      // confirm 42, clear, new entry 7
      applyStimulus(1'b0, 1'b0, 1'b1, 4);
      applyStimulus(1'b0, 1'b0, 1'b1, 2);
      applyStimulus(1'b0, 1'b1, 1'b0, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 7);
      waitDrain("drain_42");

      // clear and confirm together mid-entry
      applyStimulus(1'b0, 1'b0, 1'b1, 3);
      applyStimulus(1'b1, 1'b1, 1'b0, 0);
      waitDrain("drain_simult");

      // randomized presses, including simultaneous keys
      for (int n = 0; n < 60; n++) begin
         op = $urandom_range(0, 11);
         d = $urandom_range(0, 11);
         case (op)
            0:       applyStimulus(1'b1, 1'b0, 1'b0, d);
            1, 2:    applyStimulus(1'b0, 1'b1, 1'b0, d);
            3:       applyStimulus(1'b1, 1'b1, 1'b0, d);
            4:       applyStimulus(1'b0, 1'b1, 1'b1, d);
            5:       applyStimulus(1'b1, 1'b0, 1'b1, d);
            default: applyStimulus(1'b0, 1'b0, 1'b1, d);
         endcase
      end
      waitDrain("drain_random");

      // asynchronous reset in the middle of an entry
      applyStimulus(1'b0, 1'b0, 1'b1, 5);
      applyStimulus(1'b0, 1'b1, 1'b0, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 5);
      applyStimulus(1'b0, 1'b0, 1'b1, 1);
      waitDrain("drain_prereset");
      @(posedge clk);
      #3 rst = 1'b1;
      modelReset();
      #1 checkAllZero("async_reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b1, 8);
      waitDrain("drain_postreset");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
